video_pixel_fifo: RTL and testbench

- Parametrised successor to the single-shot video buffer in the VGA path.
- Circular FIFO between the frame/line fetch logic and the VGA timing generator.
- Accepts multi-pixel words through a valid/ready handshake and emits one pixel per enabled read.
- Reports fill level, a refill-request watermark, full/empty, and a sticky underflow flag, so the fetcher can stream continuously instead of reloading a fixed block.

---
 rtl/video_pixel_fifo.sv | 128 ++++++++++++
 tb/tb_video_pixel_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_fifo.sv
// rtl/video_pixel_fifo.sv - word-in / pixel-out circular FIFO between line fetch and VGA timing
//
// Ports:
//   clk25MHz     pixel clock, all logic on its rising edge
//   reset_n      asynchronous active-low reset
//   wr_data      PIX_PER_WORD pixels, pixel 0 in the low bits and emitted first
//   wr_valid     word offered by the fetcher
//   wr_ready     room for a whole word (decoded from the registered level only)
//   rd_en        pop one pixel (active-video enable)
//   flush        synchronous clear at frame start, overrides write and read
//   video        registered pixel output
//   video_valid  video was popped on the previous edge
//   level        pixels stored
//   watermark_on level <= WATERMARK, refill request
//   empty/full   level == 0 / level == capacity
//   underflow    sticky, rd_en seen while empty; cleared by flush or reset
//
// Optional build macro VIDEO_PIXEL_FIFO_BLANK_EN: a read while empty drives
// video to 0 instead of holding the last pixel.
module video_pixel_fifo #(
    parameter int PIXEL_W      = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int DEPTH_WORDS  = 16,
    parameter int WATERMARK    = 16
) (
    input  logic                                             clk25MHz,
    input  logic                                             reset_n,
    input  logic [PIXEL_W*PIX_PER_WORD-1:0]                  wr_data,
    input  logic                                             wr_valid,
    output logic                                             wr_ready,
    input  logic                                             rd_en,
    input  logic                                             flush,
    output logic [PIXEL_W-1:0]                               video,
    output logic                                             video_valid,
    output logic [$clog2(DEPTH_WORDS*PIX_PER_WORD+1)-1:0]    level,
    output logic                                             watermark_on,
    output logic                                             empty,
    output logic                                             full,
    output logic                                             underflow
);

    localparam int CAP    = DEPTH_WORDS * PIX_PER_WORD;
    localparam int LVL_W  = $clog2(CAP + 1);
    localparam int WORD_W = PIXEL_W * PIX_PER_WORD;
    localparam int WP_W   = $clog2(DEPTH_WORDS);
    localparam int PI_W   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    logic [WORD_W-1:0]  mem [DEPTH_WORDS];
    logic [WP_W-1:0]    wr_ptr;
    // Read pointer split into word index and pixel-within-word index so that
    // non-power-of-two PIX_PER_WORD still wraps without gaps.
    logic [WP_W-1:0]    rd_word;
    logic [PI_W-1:0]    rd_pix;
    logic [WORD_W-1:0]  rd_word_data;
    logic [PIXEL_W-1:0] rd_pixel;
    logic               wr_acc;
    logic               pop;

    assign empty        = (level == '0);
    assign full         = (level == LVL_W'(CAP));
    assign watermark_on = (level <= LVL_W'(WATERMARK));
    assign wr_ready     = (level <= LVL_W'(CAP - PIX_PER_WORD));

    // Flush wins over both sides; pop uses the registered empty, so a write
    // landing into an empty FIFO cannot be read in the same cycle.
    assign wr_acc = wr_valid && wr_ready && !flush;
    assign pop    = rd_en && !empty && !flush;

    always_comb begin
        rd_word_data = mem[rd_word];
        rd_pixel     = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (rd_pix == PI_W'(i)) begin
                rd_pixel = rd_word_data[i*PIXEL_W +: PIXEL_W];
            end
        end
    end

    // Storage is not reset: level and pointers define which entries are live.
    always_ff @(posedge clk25MHz) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_word     <= '0;
            rd_pix      <= '0;
            level       <= '0;
            video       <= '0;
            video_valid <= 1'b0;
            underflow   <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_word     <= '0;
            rd_pix      <= '0;
            level       <= '0;
            video_valid <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            video_valid <= pop;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + WP_W'(1);
            end
            if (pop) begin
                video <= rd_pixel;
                if (rd_pix == PI_W'(PIX_PER_WORD - 1)) begin
                    rd_pix  <= '0;
                    rd_word <= rd_word + WP_W'(1);
                end else begin
                    rd_pix <= rd_pix + PI_W'(1);
                end
            end else if (rd_en) begin
                underflow <= 1'b1;
`ifdef VIDEO_PIXEL_FIFO_BLANK_EN
                video <= '0;
`else
                video <= video;
`endif
            end
            level <= level + (wr_acc ? LVL_W'(PIX_PER_WORD) : LVL_W'(0))
                           - (pop ? LVL_W'(1) : LVL_W'(0));
        end
    end

endmodule

// File: tb/tb_video_pixel_fifo.sv
// tb/tb_video_pixel_fifo.sv - self-checking bench for video_pixel_fifo
module tb_video_pixel_fifo;

    localparam int PW   = 8;
    localparam int PPW  = 4;
    localparam int DW   = 16;
    localparam int CAP  = DW * PPW;

    logic          clk25MHz = 1'b0;
    logic          reset_n  = 1'b0;
    logic [31:0]   wr_data  = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          rd_en    = 1'b0;
    logic          flush    = 1'b0;
    logic [7:0]    video;
    logic          video_valid;
    logic [6:0]    level;
    logic          watermark_on;
    logic          empty;
    logic          full;
    logic          underflow;

    video_pixel_fifo #(
        .PIXEL_W(PW), .PIX_PER_WORD(PPW), .DEPTH_WORDS(DW), .WATERMARK(16)
    ) dut (
        .clk25MHz(clk25MHz), .reset_n(reset_n), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_en(rd_en), .flush(flush),
        .video(video), .video_valid(video_valid), .level(level),
        .watermark_on(watermark_on), .empty(empty), .full(full),
        .underflow(underflow)
    );

    always #20 clk25MHz = ~clk25MHz;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bench model: pixel queue, expected-output scoreboard, registered outputs.
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    logic [7:0] m_video = 8'h00;
    logic       m_vv    = 1'b0;
    logic       m_uf    = 1'b0;
    logic [7:0] pix     = 8'h10;

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        re;
        int          lvl;
        logic        emp;
        logic        wm;
        logic        ful;
        logic        rdy;
        logic        vv;
        int          vid;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_word();
        logic [31:0] w;
        for (int i = 0; i < PPW; i++) begin
            w[i*8 +: 8] = pix;
            pix = pix + 8'd1;
            if (pix == 8'h00) pix = 8'h01;
        end
        return w;
    endfunction

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic wv, input logic [31:0] wd, input logic re, input logic fl);
        int   lvl;
        logic acc;
        logic pop;
        wr_valid = wv; wr_data = wd; rd_en = re; flush = fl;
        lvl = m_q.size();
        acc = wv && ((CAP - lvl) >= PPW);
        pop = re && (lvl > 0);
        if (fl) begin
            m_q.delete();
            m_uf = 1'b0;
            m_vv = 1'b0;
        end else begin
            m_vv = pop;
            if (pop) begin
                m_video = m_q.pop_front();
                sb_q.push_back(m_video);
            end else if (re) begin
                m_uf = 1'b1;
`ifdef VIDEO_PIXEL_FIFO_BLANK_EN
                m_video = 8'h00;
`endif
            end
            if (acc) begin
                for (int i = 0; i < PPW; i++) m_q.push_back(wd[i*8 +: 8]);
            end
        end
        @(posedge clk25MHz);
        #1;
        wr_valid = 1'b0; rd_en = 1'b0; flush = 1'b0;
        chk("level", int'(level), m_q.size());
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("full", int'(full), int'(m_q.size() == CAP));
        chk("wr_ready", int'(wr_ready), int'((CAP - m_q.size()) >= PPW));
        chk("watermark_on", int'(watermark_on), int'(m_q.size() <= 16));
        chk("video_valid", int'(video_valid), int'(m_vv));
        chk("underflow", int'(underflow), int'(m_uf));
        if (video_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("video_sb", int'(video), int'(sb_q.pop_front()));
            end
        end else begin
            chk("video_hold", int'(video), int'(m_video));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 200) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", m_q.size(), 0);
    endtask

    initial begin
        logic [7:0] prev;

        tv[0] = '{1'b1, 32'h03020100, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tv[1] = '{1'b1, 32'h07060504, 1'b0, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        for (int i = 0; i < 8; i++) begin
            tv[2+i] = '{1'b0, 32'h0, 1'b1, 7 - i, (i == 7), 1'b1, 1'b0, 1'b1, 1'b1, i};
        end

        // Reset
        repeat (2) @(posedge clk25MHz);
        @(negedge clk25MHz);
        reset_n = 1'b1;
        @(posedge clk25MHz);
        #1;
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_wm", int'(watermark_on), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_video", int'(video), 0);
        chk("rst_vv", int'(video_valid), 0);
        chk("rst_uf", int'(underflow), 0);

        // 1: two words then eight reads, against constant table
        for (int i = 0; i < 10; i++) begin
            cycle(tv[i].wv, tv[i].wd, tv[i].re, 1'b0);
            chk("t1_level", int'(level), tv[i].lvl);
            chk("t1_empty", int'(empty), int'(tv[i].emp));
            chk("t1_wm", int'(watermark_on), int'(tv[i].wm));
            chk("t1_full", int'(full), int'(tv[i].ful));
            chk("t1_wr_ready", int'(wr_ready), int'(tv[i].rdy));
            chk("t1_vv", int'(video_valid), int'(tv[i].vv));
            if (tv[i].vv) chk("t1_video", int'(video), tv[i].vid);
        end

        // 2: fill to full, dropped write, read back below the word threshold
        for (int i = 0; i < 16; i++) cycle(1'b1, mk_word(), 1'b0, 1'b0);
        chk("t2_full_level", int'(level), 64);
        chk("t2_full", int'(full), 1);
        chk("t2_not_ready", int'(wr_ready), 0);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("t2_drop_level", int'(level), 64);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_lvl63", int'(level), 63);
        chk("t2_ready63", int'(wr_ready), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_lvl60", int'(level), 60);
        chk("t2_ready60", int'(wr_ready), 1);

        // 3: steady streaming across pointer wrap
        for (int k = 0; k < 200; k++) begin
            if (k % 4 == 0) cycle(1'b1, mk_word(), 1'b1, 1'b0);
            else            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (k % 4 == 3) chk("t3_level", int'(level), 60);
        end
        chk("t3_uf", int'(underflow), 0);
        drain();

        // 4: underflow, stickiness, flush clear
        prev = video;
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_uf", int'(underflow), 1);
        chk("t4_vv", int'(video_valid), 0);
`ifdef VIDEO_PIXEL_FIFO_BLANK_EN
        chk("t4_video_blank", int'(video), 0);
`else
        chk("t4_video_smear", int'(video), int'(prev));
`endif
        cycle(1'b1, mk_word(), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_uf_sticky", int'(underflow), 1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_uf_flushed", int'(underflow), 0);
        cycle(1'b1, mk_word(), 1'b1, 1'b0);
        chk("t4_wr_rd_empty_lvl", int'(level), 4);
        chk("t4_wr_rd_empty_uf", int'(underflow), 1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // 5: flush beats simultaneous write and read
        for (int i = 0; i < 5; i++) cycle(1'b1, mk_word(), 1'b0, 1'b0);
        chk("t5_lvl20", int'(level), 20);
        cycle(1'b1, mk_word(), 1'b1, 1'b1);
        chk("t5_level", int'(level), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_uf", int'(underflow), 0);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 10; i++) cycle(1'b1, mk_word(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6_lvl37", int'(level), 37);
        #10;
        reset_n = 1'b0;
        #1;
        chk("t6_level", int'(level), 0);
        chk("t6_video", int'(video), 0);
        chk("t6_vv", int'(video_valid), 0);
        chk("t6_wr_ready", int'(wr_ready), 1);
        chk("t6_empty", int'(empty), 1);
        m_q.delete(); sb_q.delete();
        m_video = 8'h00; m_vv = 1'b0; m_uf = 1'b0;
        @(negedge clk25MHz);
        reset_n = 1'b1;
        @(posedge clk25MHz);
        #1;
        cycle(1'b1, mk_word(), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
